// File: rtl/sm_subtractor.sv
// Sign-magnitude subtractor: c = a - b with magnitude-overflow and zero flags.
// A four-state handshake FSM accepts one operand pair, compares magnitudes in
// one cycle, forms the result in the next, then holds it until it is retired.
module sm_subtractor #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         neg,
    output logic         ovf,
    output logic         zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        EXEC = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t       state;

    // Captured operands and the relations registered during CMP.
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         same_sign;
    logic         a_gt;
    logic         a_eq;

    // Magnitude views of the captured operands.
    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;

    // Result formed from the registered relations, consumed in EXEC.
    logic [N-1:0] sum;
    logic [N-2:0] res_mag;
    logic         res_sign;
    logic         res_ovf;

    assign mag_a = a_reg[N-2:0];
    assign mag_b = b_reg[N-2:0];

    // Select the result magnitude/sign from the sign relation and magnitude order.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        sum      = {1'b0, mag_a} + {1'b0, mag_b};
        res_mag  = '0;
        res_sign = 1'b0;
        res_ovf  = 1'b0;
        if (!same_sign) begin
            // Opposite signs: magnitudes add; the carry out of N-1 bits is overflow.
            res_mag  = sum[N-2:0];
            res_ovf  = sum[N-1];
            res_sign = a_reg[N-1];
        end else if (a_gt) begin
            res_mag  = mag_a - mag_b;
            res_sign = a_reg[N-1];
        end else if (!a_eq) begin
            res_mag  = mag_b - mag_a;
            res_sign = ~a_reg[N-1];
        end
        // A zero magnitude (including a wrap to zero) is always reported as +0.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    // Handshake FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand and result registers are reset along with the
            // state so a reset mid-operation leaves nothing stale behind.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            same_sign <= 1'b0;
            a_gt      <= 1'b0;
            a_eq      <= 1'b0;
            c         <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here
            // updates from pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    same_sign <= (a_reg[N-1] == b_reg[N-1]);
                    a_gt      <= (mag_a > mag_b);
                    a_eq      <= (mag_a == mag_b);
                    state     <= EXEC;
                end
                EXEC: begin
                    c         <= {res_sign, res_mag};
                    neg       <= res_sign;
                    ovf       <= res_ovf;
                    zero      <= (res_mag == '0);
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_subtractor.sv
// Self-checking bench for sm_subtractor (N=16): directed corner cases,
// backpressure, reset during EXEC and randomized operands against an
// integer-arithmetic reference model.
module tb_sm_subtractor;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] c;
        logic         neg;
        logic         ovf;
        logic         zero;
    } result_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] c;
    logic         neg;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int errors = 0;

    sm_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .neg       (neg),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] observed, input logic [31:0] expected,
                         input string tag);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: signed integer difference, then map back to sign-magnitude.
    function automatic result_t model(input logic [N-1:0] ta, input logic [N-1:0] tb);
        result_t r;
        int va, vb, diff, mag, m;
        logic [N-1:0] mag_bits;
        va   = ta[N-1] ? -int'(ta[N-2:0]) : int'(ta[N-2:0]);
        vb   = tb[N-1] ? -int'(tb[N-2:0]) : int'(tb[N-2:0]);
        diff = va - vb;
        mag  = (diff < 0) ? -diff : diff;
        m    = mag % (1 << (N-1));
        mag_bits = N'(m);
        r.ovf  = (mag > (1 << (N-1)) - 1);
        r.zero = (m == 0);
        r.neg  = (diff < 0) && (m != 0);
        r.c    = {r.neg, mag_bits[N-2:0]};
        return r;
    endfunction

    // Issue one operation, check latency and result, retire after hold_cycles.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input int hold_cycles, input string tag);
        result_t exp;
        int      lat;
        exp = model(ta, tb);
        @(negedge clk);
        check(32'(in_ready), 32'd1, {tag, " in_ready idle"});
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check(32'(in_ready), 32'd0, {tag, " in_ready busy"});
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check(32'(lat), 32'd3, {tag, " latency"});
        check(32'(c), 32'(exp.c), {tag, " c"});
        check({29'd0, neg, ovf, zero}, {29'd0, exp.neg, exp.ovf, exp.zero},
              {tag, " neg/ovf/zero"});
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1}, {tag, " retire"});
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic [N-1:0] held_c;

        // Reset state.
        repeat (2) @(negedge clk);
        check({28'd0, in_ready, out_valid, neg, ovf}, {28'd0, 4'b1000}, "reset ctrl");
        check({15'd0, zero, c}, 32'd0, "reset c/zero");
        rst = 1'b0;

        // Directed cases.
        run_op(16'h0005, 16'h0003, 0, "5-3");
        run_op(16'h0003, 16'h0005, 0, "3-5");
        run_op(16'h8005, 16'h0003, 0, "-5-3");
        run_op(16'h8004, 16'h8004, 0, "-4--4");
        run_op(16'h8000, 16'h0000, 0, "-0-0");
        run_op(16'h7FFF, 16'h8001, 0, "wrap0");
        run_op(16'h7FFF, 16'h8002, 0, "wrap1");
        run_op(16'h0000, 16'h8000, 0, "0--0");
        run_op(16'h8000, 16'h8003, 0, "-0--3");
        run_op(16'hFFFF, 16'h7FFF, 1, "maxneg");

        // Backpressure: hold 5 cycles with ignored in_valid pulses.
        @(negedge clk);
        a = 16'h0010; b = 16'h0004; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check(32'(out_valid), 32'd1, "bp valid");
        held_c = c;
        check(32'(held_c), 32'h000C, "bp c");
        for (int i = 0; i < 5; i++) begin
            a = N'($urandom); b = N'($urandom); in_valid = (i % 2 == 0);
            @(negedge clk);
            check({30'd0, out_valid, in_ready}, {30'd0, 2'b10}, "bp hold ctrl");
            check(32'(c), 32'h000C, "bp hold c");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({30'd0, out_valid, in_ready}, {30'd0, 2'b01}, "bp retire");
        run_op(16'h0001, 16'h0002, 0, "after bp");

        // Reset asserted during EXEC aborts the operation.
        @(negedge clk);
        a = 16'h0123; b = 16'h0021; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check({30'd0, out_valid, in_ready}, {30'd0, 2'b01}, "rst ctrl");
        check({13'd0, neg, ovf, zero, c}, 32'd0, "rst outputs");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(32'(out_valid), 32'd0, "rst no result");
        end
        run_op(16'h0123, 16'h0021, 0, "after rst");

        // Randomized operands, biased towards equal magnitudes and zeros.
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            case ($urandom_range(0, 3))
                0: rb[N-2:0] = ra[N-2:0];
                1: ra[N-2:0] = '0;
                default: ;
            endcase
            run_op(ra, rb, int'($urandom_range(0, 3)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
